// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory master/slave pair.
package spi_mem_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_LSB = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE,
    GUARD
  } spi_state_e;

  // Bit 15 = rw, bits 14:8 = address, bits 7:0 = data.
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_sclk_div.sv
// Divider for the serial clock: emits a one-cycle tick every CLK_DIV enabled
// cycles. clr restarts the count; the count also restarts after each tick.
module spi_sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CNT_W'(CLK_DIV - 1));

  // Count enabled cycles, restarting on clear or on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_mem.sv
// SPI mode-0 master turning parallel read/write requests into 16-bit frames.
// Optional feature: define SPI_MASTER_CS_GUARD_EN to add a GUARD state that
// keeps cs high (and busy asserted) after DONE, widening the gap between frames.
module spi_master_mem #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  import spi_mem_pkg::*;

  spi_state_e         state_reg, state_next;
  logic [FRAME_W-1:0] shift_reg;
  logic [DATA_W-1:0]  rx_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic [4:0]         rise_cnt_reg;
  logic               rw_reg;
  logic               cs_reg;
  logic               sclk_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               tick;
  logic               div_clr;
  logic               div_en;
  logic               last_fall;
  spi_frame_t         frame_load;

`ifdef SPI_MASTER_CS_GUARD_EN
  localparam int GUARD_W = $clog2(2 * CLK_DIV + 1);
  logic [GUARD_W-1:0] guard_cnt_reg;
`endif

  // Assemble the outgoing frame; reads send zeros in the data field.
  always_comb begin
    frame_load      = '0;
    frame_load.rw   = rw;
    frame_load.addr = addr;
    frame_load.data = rw ? wdata : '0;
  end

  assign div_en    = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD);
  assign div_clr   = (state_next != state_reg);
  assign last_fall = tick && sclk_reg && (rise_cnt_reg == 5'(FRAME_W));

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: frame sequencing driven by divider ticks.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = SETUP;
      SETUP: if (tick) state_next = SHIFT;
      SHIFT: if (last_fall) state_next = HOLD;
      HOLD:  if (tick) state_next = DONE;
`ifdef SPI_MASTER_CS_GUARD_EN
      DONE:  state_next = GUARD;
      GUARD: if (guard_cnt_reg == '0) state_next = IDLE;
`else
      DONE:  state_next = IDLE;
      GUARD: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and serial datapath; mosi is the shift register MSB,
  // which only moves on sclk falls, so it never changes while sclk is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg     <= '0;
      rx_reg        <= '0;
      rdata_reg     <= '0;
      rise_cnt_reg  <= '0;
      rw_reg        <= 1'b0;
      cs_reg        <= 1'b1;
      sclk_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef SPI_MASTER_CS_GUARD_EN
      guard_cnt_reg <= '0;
`endif
    end else begin
      cs_reg   <= !((state_next == SETUP) || (state_next == SHIFT) || (state_next == HOLD));
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg    <= frame_load;
            rw_reg       <= rw;
            rise_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk_reg) begin
              sclk_reg     <= 1'b1;
              rx_reg       <= {rx_reg[DATA_W-2:0], miso};
              rise_cnt_reg <= rise_cnt_reg + 5'd1;
            end else begin
              sclk_reg <= 1'b0;
              if (!last_fall) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          // The last DATA_W sampled bits are the slave's read data.
          if (tick && !rw_reg) begin
            rdata_reg <= rx_reg;
          end
        end
`ifdef SPI_MASTER_CS_GUARD_EN
        // DONE already counts as the first cs-high guard cycle.
        DONE: guard_cnt_reg <= GUARD_W'(2 * CLK_DIV - 2);
        GUARD: begin
          if (guard_cnt_reg != '0) begin
            guard_cnt_reg <= guard_cnt_reg - GUARD_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign rdata = rdata_reg;
  assign cs    = cs_reg;
  assign sclk  = sclk_reg;
  assign mosi  = shift_reg[FRAME_W-1];

endmodule

// File: tb/tb_spi_master_mem.sv
// Bench for spi_master_mem: behavioural slave memory, cycle-level reference
// model derived from frame timing arithmetic, and directed plus random frames.
module tb_spi_master_mem;

  localparam int D = 2;
`ifdef SPI_MASTER_CS_GUARD_EN
  localparam int LAST_M = 34 * D + 2 * D - 1;
  localparam int GAP    = 2 * D + 1;
`else
  localparam int LAST_M = 34 * D;
  localparam int GAP    = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, cs, sclk, mosi;
  logic       miso = 1'b0;
  logic [7:0] rdata;

  spi_master_mem #(.CLK_DIV(D), .ADDR_W(7), .DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .rw   (rw),
    .addr (addr),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .rdata(rdata),
    .cs   (cs),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout required event (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem[128];
  logic [7:0]  slv_mem[128];
  bit          m_active = 1'b0;
  int          m = 0;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_rdata = '0;
  logic [7:0]  m_rd_val = '0;

  // m counts clk edges since acceptance; the whole frame is a function of m.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
      m        = 0;
      m_rdata  = '0;
    end else if (m_active) begin
      if (m == LAST_M) begin
        m_active = 1'b0;
      end else begin
        m++;
        if (m == 34 * D) begin
          if (m_frame[15]) ref_mem[m_frame[14:8]] = m_frame[7:0];
          else m_rdata = m_rd_val;
        end
      end
    end else if (start) begin
      m_active = 1'b1;
      m        = 0;
      m_frame  = {rw, addr, rw ? wdata : 8'h00};
      m_rd_val = ref_mem[addr];
    end
  end

  // Compare every output against the model on each falling clk edge.
  bit e_cs, e_done, e_busy, e_sclk;
  int e_j;
  always begin
    @(negedge clk);
    e_cs   = !(m_active && m < 34 * D);
    e_done = m_active && (m == 34 * D);
    e_busy = m_active;
    e_sclk = m_active && (m >= 2 * D) && (m < 33 * D) && (((m / D) % 2) == 0);
    check("cs", cs, e_cs);
    check("done", done, e_done);
    check("busy", busy, e_busy);
    check("sclk", sclk, e_sclk);
    check("rdata", rdata, m_rdata);
    if (m_active && m < 33 * D) begin
      e_j = (m < 3 * D) ? 0 : (m - D) / (2 * D);
      check("mosi", mosi, m_frame[15 - e_j]);
    end
  end

  // ---------------- behavioural slave ----------------
  int          s_rises = 0;
  int          s_falls = 0;
  logic [15:0] s_bits = '0;
  logic [7:0]  s_rd = '0;
  bit          s_rw = 1'b0;
  logic [15:0] last_stream = '0;
  int          last_rises = 0;

  always begin
    @(negedge cs);
    s_rises = 0;
    s_falls = 0;
    s_bits  = '0;
    miso    = 1'b0;
  end

  always begin
    @(posedge sclk);
    if (cs === 1'b0) begin
      s_bits = {s_bits[14:0], mosi};
      s_rises++;
    end
  end

  // Read data leaves the slave on falls 8..15 so it is stable at rises 9..16.
  always begin
    @(negedge sclk);
    if (cs === 1'b0) begin
      s_falls++;
      if (s_falls == 8) begin
        s_rw = s_bits[7];
        s_rd = slv_mem[s_bits[6:0]];
      end
      if (s_falls >= 8 && s_falls < 16 && !s_rw) miso = s_rd[15 - s_falls];
    end
  end

  always begin
    @(posedge cs);
    last_stream = s_bits;
    last_rises  = s_rises;
    if (s_rises == 16 && s_bits[15]) slv_mem[s_bits[14:8]] = s_bits[7:0];
    miso = 1'b0;
  end

  // cs low/high run lengths measured in clk cycles.
  int low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  always begin
    @(negedge clk);
    if (cs === 1'b0) begin
      if (high_run > 0) last_high = high_run;
      high_run = 0;
      low_run++;
    end else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      high_run++;
    end
  end

  // ---------------- stimulus ----------------
  // All tasks run in the phase just after a falling clk edge.
  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 300) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 300) timeout_fail("wait_idle");
  endtask

  task automatic do_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                          input int spur, output int lat);
    int t0, g;
    wait_idle();
    rw = r; addr = a; wdata = d; start = 1'b1;
    t0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    g = 1;
    while (done !== 1'b1 && g < 1000) begin
      start = (spur > 0 && g == spur);
      @(negedge clk); #1;
      g++;
    end
    start = 1'b0;
    if (g >= 1000) timeout_fail("wait_done");
    lat = cyc - t0;
    $display("txn rw=%0d addr=%02h wdata=%02h rdata=%02h latency=%0d rises=%0d",
             r, a, d, rdata, lat, last_rises);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, g;
    logic [7:0] v;
    logic       r;
    logic [6:0] a;
    logic [7:0] d;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      slv_mem[i] = v;
    end

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Write 0x12 <- 0xA5
    do_frame(1'b1, 7'h12, 8'hA5, 0, lat);
    check("wr_latency", lat, 69);
    check("wr_stream", last_stream, 16'h92A5);
    check("wr_cs_low", last_low, 68);
    check("wr_rises", last_rises, 16);
    check("wr_rdata_kept", rdata, 8'h00);

    // Read 0x12 back
    do_frame(1'b0, 7'h12, 8'h3C, 0, lat);
    check("rd_latency", lat, 69);
    check("rd_stream", last_stream, 16'h1200);
    check("rd_rdata", rdata, 8'hA5);

    // Spurious start inside a frame is ignored
    do_frame(1'b1, 7'h33, 8'h5A, 10, lat);
    check("spur_stream", last_stream, 16'hB35A);
    check("spur_rises", last_rises, 16);
    repeat (4) @(negedge clk);
    #1;
    check("spur_no_frame_busy", busy, 1'b0);
    check("spur_no_frame_cs", cs, 1'b1);

    // Reset at the 7th rising edge
    wait_idle();
    rw = 1'b0; addr = 7'h12; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    g = 0;
    while (s_rises != 7 && g < 500) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 500) timeout_fail("wait_rise7");
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_cs", cs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rdata", rdata, 8'h00);
    check("abort_rises", last_rises, 7);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    do_frame(1'b0, 7'h12, 8'h00, 0, lat);
    check("post_abort_rdata", rdata, 8'hA5);
    check("post_abort_latency", lat, 69);

    // Back-to-back write then read
    do_frame(1'b1, 7'h44, 8'hC3, 0, lat);
    do_frame(1'b0, 7'h44, 8'h00, 0, lat);
    check("b2b_rdata", rdata, 8'hC3);
    check("b2b_gap", last_high, GAP);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      r = 1'($urandom);
      a = 7'($urandom);
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1;
      do_frame(r, a, d, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 60) : 0, lat);
      check("rand_stream", last_stream, {r, a, r ? d : 8'h00});
      if (!r) check("rand_rdata", rdata, ref_mem[a]);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
